apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Single-slave APB (AMBA 3) master bridge.
- Converts a simple local request (trans_i, addr_i, wdata_i, wr_rd_i) into APB SETUP/ACCESS phases and returns read data and slave error to the local side.
- Sits between a local controller and one APB slave; pready/pslverr/prdata come from the slave.

Parameters:
- ADDR_WIDTH, 32, width of addr_i and paddr
- DATA_WIDTH, 32, width of wdata_i, pwdata, prdata and rdata_o

Ports:
- pclk  input  1  clock; all logic on rising edge
- preset_n  input  1  synchronous, active-high reset (asserted = 1, sampled on pclk rising edge)
- trans_i  input  1  local transfer request, sampled when the master can accept
- addr_i  input  ADDR_WIDTH  local transfer address
- wdata_i  input  DATA_WIDTH  local write data
- wr_rd_i  input  1  direction: 1 = write, 0 = read
- pready  input  1  APB slave ready
- pslverr  input  1  APB slave error, valid when pready = 1 in ACCESS
- prdata  input  DATA_WIDTH  APB read data, valid when pready = 1 in ACCESS on a read
- pselx  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- rdata_o  output  DATA_WIDTH  captured read data to local side
- trans_err_o  output  1  transfer-error pulse to local side

Behaviour:
- All outputs are registered.
- Reset (preset_n = 1 at a rising edge): state IDLE; all outputs 0.
- Reset mid-transfer aborts immediately; no completion or error is reported.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - pselx = 0, penable = 0.
  - If trans_i = 1 at an edge: latch addr_i into paddr, wr_rd_i into pwrite, and (for writes) wdata_i into pwdata; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - pselx = 1, penable = 0, for exactly one cycle.
  - Always go to ACCESS.
- ACCESS:
  - pselx = 1, penable = 1.
  - paddr, pwrite and pwdata are held stable.
  - pready = 0: stay in ACCESS (unbounded wait states).
  - pready = 1 (completion edge):
    - Read: rdata_o <= prdata.
    - trans_err_o <= pslverr (read or write).
    - If trans_i = 1 on the same edge: latch the new request and go directly to SETUP (back-to-back; pselx stays 1, penable drops to 0).
    - Else go to IDLE.
- trans_i is ignored in SETUP and in non-completing ACCESS cycles. The requester holds trans_i and its address/data until accepted; the master never queues requests.
- Latency: trans_i sampled at edge N gives SETUP in cycle N+1 and ACCESS from N+2. With zero wait states, the result appears at N+3 (rdata_o / trans_err_o valid).
- trans_err_o is a one-cycle pulse, asserted only in the cycle after a completion with pslverr = 1; otherwise 0.
- rdata_o holds its value until the next read completes. Writes and errored reads still update rdata_o on reads only (errored reads capture prdata as-is).
- After completion, paddr/pwrite/pwdata keep their last values in IDLE.
- On a read, pwdata retains its previous value.
- pslverr and prdata are ignored outside the ACCESS + pready = 1 edge.

Test Plan:
- Reset: hold preset_n = 1 for 2 cycles -> all outputs 0; state IDLE; release and idle for 5 cycles -> pselx stays 0.
- Zero-wait write: trans_i = 1, wr_rd_i = 1, addr_i = 0x10, wdata_i = 0xDEADBEEF for one cycle, pready = 1 -> next cycle pselx = 1/penable = 0/pwrite = 1/paddr = 0x10/pwdata = 0xDEADBEEF; following cycle penable = 1; then pselx = 0, trans_err_o = 0.
- Read with 3 wait states: addr_i = 0x20, wr_rd_i = 0; pready low 3 ACCESS cycles, then pready = 1 with prdata = 0x12345678 -> penable high 4 cycles, paddr stable 0x20, rdata_o = 0x12345678 afterwards and held.
- Slave error: write to 0x30 completing with pslverr = 1 -> trans_err_o = 1 for exactly one cycle, rdata_o unchanged.
- Back-to-back: trans_i held high across two requests (write 0x40, then read 0x44) -> pselx stays 1 across the boundary; penable pattern 0,1,0,1; second paddr = 0x44, pwrite = 0.
- Reset mid-ACCESS: assert preset_n while penable = 1 -> next cycle pselx = penable = 0, trans_err_o = 0, rdata_o = 0.

Source files
------------

// File: rtl/apb_master.sv
// Purpose : single-slave APB (AMBA 3) master; turns a local request into SETUP/ACCESS phases.
// Latency : request sampled at edge N -> SETUP in N+1, ACCESS from N+2, result visible from N+3 with no wait states.
// Backpr. : trans_i is accepted only in IDLE or on the ACCESS completion edge; pready low stretches ACCESS indefinitely.
//
// Ports:
//   pclk, preset_n (synchronous, active-high reset)
//   local side : trans_i, addr_i, wdata_i, wr_rd_i -> rdata_o, trans_err_o
//   APB side   : pselx, penable, pwrite, paddr, pwdata -> slave; pready, pslverr, prdata <- slave
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  trans_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wr_rd_i,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  trans_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  pselx_d, penable_d, pwrite_d, trans_err_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d, rdata_d;
    logic                  accept;

    // Next-state and next-output logic. Outputs are registered, so pselx/penable
    // are derived from the state we are about to enter rather than the current one.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr;
        pwrite_d    = pwrite;
        pwdata_d    = pwdata;
        rdata_d     = rdata_o;
        trans_err_d = 1'b0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (trans_i) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (!pwrite) begin
                        rdata_d = prdata;
                    end
                    trans_err_d = pslverr;
                    if (trans_i) begin
                        // Back-to-back: skip IDLE so pselx stays high across the boundary.
                        accept  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            paddr_d  = addr_i;
            pwrite_d = wr_rd_i;
            // Reads leave the previous write data on pwdata.
            if (wr_rd_i) begin
                pwdata_d = wdata_i;
            end
        end

        pselx_d   = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk) begin
        if (preset_n) begin
            state_q     <= IDLE;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rdata_o     <= '0;
            trans_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            pselx       <= pselx_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            rdata_o     <= rdata_d;
            trans_err_o <= trans_err_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Purpose : self-checking bench for apb_master against a transaction-level model.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : slave wait states and spurious local requests are injected at random.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          trans_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          wr_rd_i;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] rdata_o;
    logic          trans_err_o;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .trans_i     (trans_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_rd_i     (wr_rd_i),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .rdata_o     (rdata_o),
        .trans_err_o (trans_err_o)
    );

    always #5 pclk = ~pclk;

    // One local transfer and how the slave answers it.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          err;
        logic [DW-1:0] rd;
        logic          chain;   // next request is presented on this one's completion edge
    } txn_t;

    txn_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Architectural state visible to the local side and the bus.
    logic [AW-1:0] m_paddr;
    logic          m_pwrite;
    logic [DW-1:0] m_pwdata;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph, input logic psel, input logic pen, input logic err);
        chk({ph, " pselx"},       32'(pselx),       32'(psel));
        chk({ph, " penable"},     32'(penable),     32'(pen));
        chk({ph, " paddr"},       paddr,            m_paddr);
        chk({ph, " pwrite"},      32'(pwrite),      32'(m_pwrite));
        chk({ph, " pwdata"},      pwdata,           m_pwdata);
        chk({ph, " rdata_o"},     rdata_o,          m_rdata);
        chk({ph, " trans_err_o"}, 32'(trans_err_o), 32'(err));
    endtask

    task automatic model_reset();
        m_paddr  = '0;
        m_pwrite = 1'b0;
        m_pwdata = '0;
        m_rdata  = '0;
    endtask

    task automatic present(input txn_t t);
        trans_i = 1'b1;
        addr_i  = t.addr;
        wr_rd_i = t.wr;
        wdata_i = t.wdata;
    endtask

    // Values the DUT must ignore in the current cycle.
    task automatic garbage();
        trans_i = 1'($urandom % 2);
        addr_i  = $urandom;
        wdata_i = $urandom;
        wr_rd_i = 1'($urandom % 2);
        prdata  = $urandom;
        pslverr = 1'($urandom % 2);
    endtask

    // Runs the queued transfers. Entry and exit: just after a rising edge, master idle.
    task automatic run_queue();
        txn_t t;
        logic exp_err;
        logic chained;
        exp_err = 1'b0;
        present(q[0]);
        pready = 1'($urandom % 2);
        @(posedge pclk); #1;
        for (int i = 0; i < q.size(); i++) begin
            t = q[i];
            chained = t.chain && (i + 1 < q.size());
            m_paddr  = t.addr;
            m_pwrite = t.wr;
            if (t.wr) m_pwdata = t.wdata;
            garbage();
            pready = 1'($urandom % 2);
            @(negedge pclk); check_all("setup", 1'b1, 1'b0, exp_err);
            @(posedge pclk); #1;
            for (int w = 0; w <= t.waits; w++) begin
                if (w < t.waits) begin
                    garbage();
                    pready = 1'b0;
                end else begin
                    pready  = 1'b1;
                    prdata  = t.rd;
                    pslverr = t.err;
                    if (chained) present(q[i+1]);
                    else begin
                        garbage();
                        pready  = 1'b1;
                        prdata  = t.rd;
                        pslverr = t.err;
                        trans_i = 1'b0;
                    end
                end
                @(negedge pclk); check_all("access", 1'b1, 1'b1, 1'b0);
                @(posedge pclk); #1;
            end
            if (!t.wr) m_rdata = t.rd;
            exp_err = t.err;
            if (!chained) begin
                garbage();
                trans_i = 1'b0;
                pready  = 1'($urandom % 2);
                @(negedge pclk); check_all("done", 1'b0, 1'b0, exp_err);
                @(posedge pclk); #1;
                @(negedge pclk); check_all("idle", 1'b0, 1'b0, 1'b0);
                @(posedge pclk); #1;
                exp_err = 1'b0;
                if (i + 1 < q.size()) begin
                    present(q[i+1]);
                    @(posedge pclk); #1;
                end
            end
        end
        q.delete();
    endtask

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input int waits, input logic err, input logic [DW-1:0] rd,
                                input logic chain);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.waits = waits;
        t.err = err; t.rd = rd; t.chain = chain;
        return t;
    endfunction

    function automatic txn_t rnd();
        return mk(1'($urandom % 2), $urandom, $urandom, int'($urandom_range(0, 3)),
                  1'($urandom % 4 == 0), $urandom, 1'($urandom % 2));
    endfunction

    initial begin
        preset_n = 1'b1;
        trans_i  = 1'b0;
        addr_i   = '0;
        wdata_i  = '0;
        wr_rd_i  = 1'b0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        model_reset();

        // Reset held for two edges, then five idle cycles.
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        @(negedge pclk); check_all("reset", 1'b0, 1'b0, 1'b0);
        preset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge pclk); #1;
            @(negedge pclk); check_all("post_reset_idle", 1'b0, 1'b0, 1'b0);
        end
        @(posedge pclk); #1;

        // Zero-wait write.
        q.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0));
        run_queue();
        // Read with three wait states.
        q.push_back(mk(1'b0, 32'h20, 32'h0BAD0BAD, 3, 1'b0, 32'h12345678, 1'b0));
        run_queue();
        // Errored write: error pulse, read data untouched.
        q.push_back(mk(1'b1, 32'h30, 32'hCAFEF00D, 1, 1'b1, 32'h55AA55AA, 1'b0));
        run_queue();
        // Back-to-back write then read.
        q.push_back(mk(1'b1, 32'h40, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h87654321, 1'b0));
        run_queue();
        // Errored read chained into a write.
        q.push_back(mk(1'b0, 32'h50, 32'h0, 2, 1'b1, 32'hFEEDFACE, 1'b1));
        q.push_back(mk(1'b1, 32'h54, 32'h13579BDF, 0, 1'b0, 32'h0, 1'b0));
        run_queue();

        // Random sequences of up to four transfers.
        for (int s = 0; s < 40; s++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) q.push_back(rnd());
            run_queue();
        end

        // Reset in the middle of ACCESS, with the slave trying to complete with an error.
        q.push_back(mk(1'b0, 32'h60, 32'h0, 0, 1'b0, 32'h0F0F0F0F, 1'b0));
        run_queue();
        present(mk(1'b1, 32'h70, 32'h11112222, 0, 1'b0, 32'h0, 1'b0));
        @(posedge pclk); #1;
        trans_i = 1'b0;
        pready  = 1'b0;
        @(posedge pclk); #1;
        m_paddr  = 32'h70;
        m_pwrite = 1'b1;
        m_pwdata = 32'h11112222;
        preset_n = 1'b1;
        pready   = 1'b1;
        pslverr  = 1'b1;
        prdata   = 32'h99999999;
        @(negedge pclk); check_all("pre_abort", 1'b1, 1'b1, 1'b0);
        @(posedge pclk); #1;
        model_reset();
        preset_n = 1'b0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        @(negedge pclk); check_all("abort", 1'b0, 1'b0, 1'b0);
        @(posedge pclk); #1;

        // Recovery after the abort.
        q.push_back(rnd());
        q.push_back(rnd());
        run_queue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
